// File: rtl/rv_test_monitor_pkg.sv
// Shared encodings for the test-status monitor: trap instruction words and status/state values.
package rv_test_monitor_pkg;

    typedef enum logic [2:0] {
        TM_RUN        = 3'd0,
        TM_PASS       = 3'd1,
        TM_FAIL       = 3'd2,
        TM_TIMEOUT    = 3'd3,
        TM_DEBUG_STOP = 3'd4
    } tm_state_e;

    localparam logic [31:0] ECALL_INSN  = 32'h00000073;
    localparam logic [31:0] EBREAK_INSN = 32'h00100073;

    function automatic logic tm_is_terminal(input tm_state_e s);
        return s != TM_RUN;
    endfunction

endpackage

// File: rtl/rv_test_monitor_event_counter.sv
// Free-running event counter with synchronous clear (dominant) and count enable.
module rv_event_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/rv_test_monitor.sv
// Snoops the fetch bus and latches a sticky PASS/FAIL/TIMEOUT/DEBUG_STOP status, halting the CPU.
// Define RV_TEST_MONITOR_PC_STOP_EN to compile in the debug PC-stop comparator.
module rv_test_monitor
    import rv_test_monitor_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     CNT_WIDTH      = 32,
    parameter int unsigned     TIMEOUT_CYCLES = 50000,
    parameter logic [XLEN-1:0] STOP_PC        = XLEN'(32'h000000A4)
) (
    input  logic                 sysClk,
    input  logic                 sysRes,
    input  logic [XLEN-1:0]      instrBusData,
    input  logic                 instrValid,
    input  logic [XLEN-1:0]      pc,
    input  logic                 statusAck,
    output logic                 done,
    output logic [2:0]           status,
    output logic                 cpuHalt,
    output logic [XLEN-1:0]      haltPc,
    output logic [CNT_WIDTH-1:0] cycleCount,
    output logic [CNT_WIDTH-1:0] instrCount
);

    tm_state_e       state_q, state_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] halt_pc_q, halt_pc_d;

    logic ecall_hit;
    logic ebreak_hit;
    logic pc_stop_hit;
    logic timeout_hit;
    logic cyc_en;
    logic ins_en;
    logic cnt_clr;

    assign ecall_hit   = instrValid && (instrBusData == XLEN'(ECALL_INSN));
    assign ebreak_hit  = instrValid && (instrBusData == XLEN'(EBREAK_INSN));
    assign timeout_hit = (cycleCount == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

`ifdef RV_TEST_MONITOR_PC_STOP_EN
    assign pc_stop_hit = instrValid && (pc == STOP_PC);
`else
    logic unused_stop_pc;
    assign unused_stop_pc = ^STOP_PC;
    assign pc_stop_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        halt_pc_d = halt_pc_q;
        cyc_en    = 1'b0;
        ins_en    = 1'b0;
        cnt_clr   = 1'b0;
        if (state_q == TM_RUN) begin
            // The terminating fetch still counts; the cycle counter stops on the exit cycle.
            ins_en = instrValid;
            if (ecall_hit) begin
                state_d = TM_PASS;
            end else if (ebreak_hit) begin
                state_d = TM_FAIL;
            end else if (pc_stop_hit) begin
                state_d = TM_DEBUG_STOP;
            end else if (timeout_hit) begin
                state_d = TM_TIMEOUT;
            end else begin
                cyc_en = 1'b1;
            end
            if (state_d != TM_RUN) begin
                halt_pc_d = pc;
            end
        end else if (statusAck) begin
            state_d   = TM_RUN;
            halt_pc_d = '0;
            cnt_clr   = 1'b1;
        end
        done_d = tm_is_terminal(state_d);
    end

    always_ff @(posedge sysClk) begin
        if (sysRes) begin
            state_q   <= TM_RUN;
            done_q    <= 1'b0;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    rv_event_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cycle_cnt (
        .clk_i   (sysClk),
        .clr_i   (sysRes | cnt_clr),
        .en_i    (cyc_en),
        .count_o (cycleCount)
    );

    rv_event_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_instr_cnt (
        .clk_i   (sysClk),
        .clr_i   (sysRes | cnt_clr),
        .en_i    (ins_en),
        .count_o (instrCount)
    );

    assign status  = state_q;
    assign done    = done_q;
    assign cpuHalt = done_q;
    assign haltPc  = halt_pc_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Self-checking bench for rv_test_monitor: directed test-plan scenarios plus randomized traffic vs. a reference model.
module tb_rv_test_monitor;

    localparam int unsigned TMO      = 16;
    localparam logic [31:0] ECALL_W  = 32'h00000073;
    localparam logic [31:0] EBREAK_W = 32'h00100073;
    localparam logic [31:0] NOP_W    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic        ack = 1'b0;
    logic        done_o;
    logic [2:0]  status_o;
    logic        halt_o;
    logic [31:0] halt_pc_o;
    logic [31:0] cyc_o;
    logic [31:0] ins_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: status code, captured pc and the two counts.
    int unsigned m_st = 0;
    logic [31:0] m_hp = '0;
    int unsigned m_cc = 0;
    int unsigned m_ic = 0;

`ifdef RV_TEST_MONITOR_PC_STOP_EN
    localparam bit PC_STOP_ON = 1'b1;
`else
    localparam bit PC_STOP_ON = 1'b0;
`endif

    rv_test_monitor #(
        .XLEN           (32),
        .CNT_WIDTH      (32),
        .TIMEOUT_CYCLES (TMO),
        .STOP_PC        (32'h000000A4)
    ) dut (
        .sysClk       (clk),
        .sysRes       (rst),
        .instrBusData (instr),
        .instrValid   (valid),
        .pc           (pc_in),
        .statusAck    (ack),
        .done         (done_o),
        .status       (status_o),
        .cpuHalt      (halt_o),
        .haltPc       (halt_pc_o),
        .cycleCount   (cyc_o),
        .instrCount   (ins_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_edge();
        if (rst) begin
            m_st = 0; m_hp = '0; m_cc = 0; m_ic = 0;
        end else if (m_st == 0) begin
            if (valid) m_ic++;
            if (valid && instr == ECALL_W)                  m_st = 1;
            else if (valid && instr == EBREAK_W)            m_st = 2;
            else if (PC_STOP_ON && valid && pc_in == 32'hA4) m_st = 4;
            else if (m_cc == TMO - 1)                       m_st = 3;
            else                                             m_cc++;
            if (m_st != 0) m_hp = pc_in;
        end else if (ack) begin
            m_st = 0; m_hp = '0; m_cc = 0; m_ic = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("status",  64'(status_o),  64'(m_st));
        check("done",    64'(done_o),    64'(m_st != 0));
        check("cpuHalt", 64'(halt_o),    64'(m_st != 0));
        check("haltPc",  64'(halt_pc_o), 64'(m_hp));
        check("cycles",  64'(cyc_o),     64'(m_cc));
        check("instrs",  64'(ins_o),     64'(m_ic));
    endtask

    task automatic drive(input logic [31:0] w, input logic v, input logic [31:0] p, input logic a);
        instr = w; valid = v; pc_in = p; ack = a;
        step();
    endtask

    task automatic restart();
        drive(NOP_W, 1'b0, 32'h0, 1'b1);
        check("restart_status", 64'(status_o), 64'd0);
        check("restart_cycles", 64'(cyc_o), 64'd0);
        check("restart_instrs", 64'(ins_o), 64'd0);
        ack = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        drive(NOP_W, 1'b1, 32'h0, 1'b0);
        drive(ECALL_W, 1'b1, 32'h0, 1'b1);
        check("reset_status", 64'(status_o), 64'd0);
        check("reset_haltPc", 64'(halt_pc_o), 64'd0);
        rst = 1'b0;

        // ECALL on the 10th fetch at pc 0x40
        for (int i = 0; i < 9; i++) drive(NOP_W, 1'b1, 32'(i * 4), 1'b0);
        check("pre_ecall_done", 64'(done_o), 64'd0);
        drive(ECALL_W, 1'b1, 32'h40, 1'b0);
        check("ecall_status", 64'(status_o), 64'd1);
        check("ecall_done", 64'(done_o), 64'd1);
        check("ecall_haltPc", 64'(halt_pc_o), 64'h40);
        check("ecall_instrs", 64'(ins_o), 64'd10);
        drive(EBREAK_W, 1'b1, 32'h44, 1'b0);
        check("pass_sticky", 64'(status_o), 64'd1);
        restart();

        // EBREAK at 0x1C, later ECALL ignored
        for (int i = 0; i < 3; i++) drive(NOP_W, 1'b1, 32'(i * 4), 1'b0);
        drive(EBREAK_W, 1'b1, 32'h1C, 1'b0);
        check("ebreak_status", 64'(status_o), 64'd2);
        check("ebreak_haltPc", 64'(halt_pc_o), 64'h1C);
        for (int i = 0; i < 4; i++) drive(ECALL_W, 1'b1, 32'h20, 1'b0);
        check("fail_sticky", 64'(status_o), 64'd2);
        restart();

        // Timeout after exactly 16 RUN cycles
        for (int i = 0; i < 15; i++) drive(NOP_W, 1'($urandom_range(0, 1)), 32'(i * 4), 1'b0);
        check("pre_timeout_status", 64'(status_o), 64'd0);
        drive(NOP_W, 1'b1, 32'h3C, 1'b0);
        check("timeout_status", 64'(status_o), 64'd3);
        check("timeout_cycles", 64'(cyc_o), 64'd15);
        check("timeout_haltPc", 64'(halt_pc_o), 64'h3C);
        drive(NOP_W, 1'b1, 32'h40, 1'b0);
        check("timeout_frozen", 64'(cyc_o), 64'd15);
        restart();

        // ECALL in the timeout cycle wins
        for (int i = 0; i < 15; i++) drive(NOP_W, 1'b1, 32'(i * 4), 1'b0);
        drive(ECALL_W, 1'b1, 32'h3C, 1'b0);
        check("ecall_vs_timeout", 64'(status_o), 64'd1);
        check("ecall_vs_timeout_instrs", 64'(ins_o), 64'd16);
        restart();

        // Invalid fetch carrying ECALL does nothing
        drive(ECALL_W, 1'b0, 32'h10, 1'b0);
        drive(EBREAK_W, 1'b0, 32'h14, 1'b0);
        check("invalid_ecall", 64'(status_o), 64'd0);

        // PC stop at 0xA4
        drive(NOP_W, 1'b1, 32'hA4, 1'b0);
        check("pc_stop", 64'(status_o), PC_STOP_ON ? 64'd4 : 64'd0);
        drive(NOP_W, 1'b1, 32'hA8, 1'b0);
        drive(NOP_W, 1'b1, 32'hAC, 1'b1);
        check("ack_in_state", 64'(status_o), 64'd0);

        // Mid-run reset with ack asserted
        drive(NOP_W, 1'b1, 32'h0, 1'b0);
        drive(NOP_W, 1'b1, 32'h4, 1'b0);
        rst = 1'b1;
        drive(ECALL_W, 1'b1, 32'h8, 1'b1);
        check("midrun_reset_cycles", 64'(cyc_o), 64'd0);
        check("midrun_reset_instrs", 64'(ins_o), 64'd0);
        rst = 1'b0;
        ack = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [31:0] w;
            logic [31:0] p;
            r = $urandom_range(0, 79);
            w = (r == 0) ? ECALL_W : (r == 1) ? EBREAK_W : $urandom();
            p = ($urandom_range(0, 31) == 0) ? 32'hA4 : $urandom();
            rst = ($urandom_range(0, 199) == 0);
            drive(w, 1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 3) == 0));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_test_monitor.md
# rv_test_monitor

Synthesizable test-status monitor that sits directly downstream of `top`'s instruction bus and PC. It snoops every fetched word and ends the run on ECALL (pass), EBREAK (fail), watchdog timeout or an optional debug PC stop. On a terminal event it freezes the CPU and latches a sticky status. It replaces simulation-only `$finish` checks on FPGA builds and in simulation.

## Interface
- `XLEN`, 32, instruction/PC width
- `CNT_WIDTH`, 32, cycle and instruction counter width
- `TIMEOUT_CYCLES`, 50000, cycles in RUN before TIMEOUT; must be ≥1 and < 2^CNT_WIDTH
- `STOP_PC`, 32'h000000A4, debug stop address (used only with `RV_TEST_MONITOR_PC_STOP_EN`)

- `sysClk`  in  1  clock
- `sysRes`  in  1  reset; synchronous, active-high
- `instrBusData`  in  XLEN  instruction word currently on the fetch bus
- `instrValid`  in  1  fetch word valid this cycle; tie high if the CPU has no stall
- `pc`  in  XLEN  address of `instrBusData`
- `statusAck`  in  1  restart request; honoured only in a terminal state
- `done`  out  1  terminal state reached; sticky
- `status`  out  3  RUN=0, PASS=1, FAIL=2, TIMEOUT=3, DEBUG_STOP=4
- `cpuHalt`  out  1  freeze request to the CPU; equals `done`
- `haltPc`  out  XLEN  `pc` captured on the terminal event
- `cycleCount`  out  CNT_WIDTH  cycles spent in RUN
- `instrCount`  out  CNT_WIDTH  valid fetches seen in RUN

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT, DEBUG_STOP. All non-RUN states are terminal.
- ECALL match: `instrValid` and `instrBusData == 32'h00000073`.
- EBREAK match: `instrValid` and `instrBusData == 32'h00100073`.
- Matching is exact on all XLEN bits; no partial decode.
- Transitions from RUN, evaluated in this priority order:
  - ECALL → PASS
  - EBREAK → FAIL
  - PC stop (macro on: `instrValid` and `pc == STOP_PC`) → DEBUG_STOP
  - `cycleCount == TIMEOUT_CYCLES-1` → TIMEOUT
  - otherwise stay in RUN
- In RUN: `cycleCount` increments every cycle; `instrCount` increments on `instrValid`. Neither counter wraps before TIMEOUT fires.
- On entry to any terminal state:
  - `haltPc` takes `pc`; for TIMEOUT it takes `pc` of that cycle.
  - Counters freeze.
- Terminal states hold indefinitely. Later fetches, including a further ECALL or EBREAK, are ignored.
- Terminal state + `statusAck` → RUN next cycle, with both counters and `haltPc` cleared to 0.
- `statusAck` is ignored in RUN.

## Timing
- Reset values: state RUN, `status`=0, `done`=0, `cpuHalt`=0, `haltPc`=0, `cycleCount`=0, `instrCount`=0.
- All outputs are registered.
- Event sampled at edge N → `done`/`status`/`haltPc` valid after edge N, i.e. 1 cycle of latency. The CPU may fetch one more word before halting; that word is ignored.
- Same-cycle ECALL and timeout → PASS. A terminating instruction also counts in `instrCount`.
- `sysRes` overrides everything, including mid-run and in terminal states.
- `statusAck` and `sysRes` asserted together → reset wins.

## Configuration
- `RV_TEST_MONITOR_PC_STOP_EN` defined: PC-stop comparator and the DEBUG_STOP transition are compiled in.
- Not defined: no comparator; `STOP_PC` is unused; encoding 4 is never produced.

## Structure
- `src/constants.vh` holds:
  - `` `ECALL `` and `` `EBREAK `` encodings
  - the five `status` encodings (`` `TM_RUN `` … `` `TM_DEBUG_STOP ``)
- One sub-module, `rv_event_counter`: CNT_WIDTH counter with sync clear and enable, instantiated twice.
- Module lives in `src/components/`; `top` wires `cpuHalt` into the CPU clock-enable.

## Test plan
- Reset, then ECALL (32'h00000073) at cycle 10, pc 32'h40 → PASS; `done`=1 after the next edge; `haltPc`=32'h40; `instrCount`=10 with `instrValid` held high.
- EBREAK (32'h00100073) at pc 32'h1C → FAIL; subsequent ECALL ignored; status stays 2.
- With `TIMEOUT_CYCLES`=16 and no trap → TIMEOUT after exactly 16 RUN cycles; `cycleCount`=15 frozen.
- ECALL on the same cycle the timeout fires → PASS; also `instrValid`=0 with ECALL on the bus → no transition.
- Macro on, pc 32'hA4 valid → DEBUG_STOP (status 4); macro off → same stimulus keeps RUN.
- In PASS, pulse `statusAck` → RUN with counters 0; `sysRes` pulsed mid-run → all outputs return to reset values next cycle.
